// File: rtl/mem_engine_pkg.sv
// Shared types and defaults for the block memory engine.
package mem_engine_pkg;

  localparam int unsigned ADDR_W_DEF = 8;
  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned LEN_W_DEF  = 8;

  typedef enum logic [1:0] {
    MODE_COPY = 2'b00,
    MODE_FILL = 2'b01,
    MODE_CSUM = 2'b10,
    MODE_RSVD = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RD   = 2'b01,
    ST_WR   = 2'b10,
    ST_FIN  = 2'b11
  } state_e;

endpackage

// File: rtl/mem_addr_gen.sv
// Base + running index pointer with modulo-2^ADDR_W address and last-byte flag.
module mem_addr_gen
  import mem_engine_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned LEN_W  = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              load_i,
  input  logic              inc_i,
  input  logic [ADDR_W-1:0] base_i,
  input  logic [LEN_W-1:0]  len_i,
  output logic [ADDR_W-1:0] addr_c,
  output logic              last_c
);

  logic [ADDR_W-1:0] base_q, base_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  idx_q, idx_d;

  always_comb begin
    base_d = base_q;
    len_d  = len_q;
    idx_d  = idx_q;
    if (load_i) begin
      base_d = base_i;
      len_d  = len_i;
      idx_d  = '0;
    end else if (inc_i) begin
      idx_d = idx_q + LEN_W'(1);
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      base_q <= '0;
      len_q  <= '0;
      idx_q  <= '0;
    end else begin
      base_q <= base_d;
      len_q  <= len_d;
      idx_q  <= idx_d;
    end
  end

  assign addr_c = base_q + ADDR_W'(idx_q);
  assign last_c = (idx_q == len_q - LEN_W'(1));

endmodule

// File: rtl/mem_block_engine.sv
// Block copy / fill / checksum initiator for the 8-bit data memory.
// Strobes, Address and WriteData are decoded from the registered state.
module mem_block_engine
  import mem_engine_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned LEN_W  = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  length,
  input  logic [DATA_W-1:0] fill_value,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] checksum,
  output logic              MemRead,
  output logic              MemWrite,
  output logic [ADDR_W-1:0] Address,
  output logic [DATA_W-1:0] WriteData,
  input  logic [DATA_W-1:0] ReadData
);

  state_e            state_q, state_d;
  mode_e             mode_q, mode_d, req_mode;
  logic [DATA_W-1:0] fill_q, fill_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] csum_q, csum_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] addr_hold_q, addr_hold_d;
  logic              load_c, src_inc_c, dst_inc_c;
  logic [ADDR_W-1:0] src_a_c, dst_a_c;
  logic              src_last_c, dst_last_c;

  assign req_mode = mode_e'(mode);

  mem_addr_gen #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_src_gen (
    .clk(clk), .clr(clr), .load_i(load_c), .inc_i(src_inc_c),
    .base_i(src_addr), .len_i(length), .addr_c(src_a_c), .last_c(src_last_c)
  );

  mem_addr_gen #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_dst_gen (
    .clk(clk), .clr(clr), .load_i(load_c), .inc_i(dst_inc_c),
    .base_i(dst_addr), .len_i(length), .addr_c(dst_a_c), .last_c(dst_last_c)
  );

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    fill_d      = fill_q;
    data_d      = data_q;
    csum_d      = csum_q;
    err_d       = err_q;
    load_c      = 1'b0;
    src_inc_c   = 1'b0;
    dst_inc_c   = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    Address     = addr_hold_q;
    WriteData   = '0;
    busy        = 1'b0;
    done        = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          load_c = 1'b1;
          mode_d = req_mode;
          fill_d = fill_value;
          err_d  = (req_mode == MODE_RSVD);
          if (req_mode == MODE_CSUM) csum_d = '0;
          if (req_mode == MODE_RSVD || length == '0) state_d = ST_FIN;
          else if (req_mode == MODE_FILL)            state_d = ST_WR;
          else                                       state_d = ST_RD;
        end
      end
      ST_RD: begin
        busy    = 1'b1;
        MemRead = 1'b1;
        Address = src_a_c;
        if (abort) begin
          state_d = ST_FIN;
        end else begin
          data_d    = ReadData;
          src_inc_c = 1'b1;
          if (mode_q == MODE_CSUM) begin
            csum_d = csum_q + ReadData;
            if (src_last_c) state_d = ST_FIN;
          end else begin
            state_d = ST_WR;
          end
        end
      end
      ST_WR: begin
        busy      = 1'b1;
        MemWrite  = 1'b1;
        Address   = dst_a_c;
        WriteData = (mode_q == MODE_FILL) ? fill_q : data_q;
        if (abort) begin
          state_d = ST_FIN;
        end else begin
          dst_inc_c = 1'b1;
          if (dst_last_c)                state_d = ST_FIN;
          else if (mode_q == MODE_COPY)  state_d = ST_RD;
        end
      end
      ST_FIN: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
    endcase

    // Address keeps the last issued value once the strobes drop.
    addr_hold_d = Address;
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q     <= ST_IDLE;
      mode_q      <= MODE_COPY;
      fill_q      <= '0;
      data_q      <= '0;
      csum_q      <= '0;
      err_q       <= 1'b0;
      addr_hold_q <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      fill_q      <= fill_d;
      data_q      <= data_d;
      csum_q      <= csum_d;
      err_q       <= err_d;
      addr_hold_q <= addr_hold_d;
    end
  end

  assign err      = err_q;
  assign checksum = csum_q;

endmodule

// File: tb/tb_mem_block_engine.sv
// Directed bench for mem_block_engine: a 32-byte memory, a reference model of
// each block operation's bus trace and memory effect, and a per-cycle compare.
module tb_mem_block_engine;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [7:0] src_addr = 8'h00, dst_addr = 8'h00, length = 8'h00, fill_value = 8'h00;
  logic       busy, done, err, MemRead, MemWrite;
  logic [7:0] checksum, Address, WriteData, ReadData;

  logic [7:0] mem [32];
  logic [7:0] ref_mem [32];
  bit         mem_loaded = 1'b0;

  typedef struct packed {
    logic       wr;
    logic [7:0] a;
    logic [7:0] d;
  } op_t;

  op_t        exp_q[$];
  logic [7:0] exp_csum = 8'h00;
  logic [7:0] exp_last_addr = 8'h00;
  logic       exp_err = 1'b0;
  int         n_chk = 0;
  int         n_pass = 0;
  bit         chk_en = 1'b0;
  int         lat;

  mem_block_engine dut (
    .clk(clk), .clr(clr), .start(start), .mode(mode),
    .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
    .fill_value(fill_value), .abort(abort), .busy(busy), .done(done),
    .err(err), .checksum(checksum), .MemRead(MemRead), .MemWrite(MemWrite),
    .Address(Address), .WriteData(WriteData), .ReadData(ReadData)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 16; i++) begin
        mem[i]      <= 8'(i);
        mem[i + 16] <= 8'(-i);
      end
      mem_loaded <= 1'b1;
    end else if (MemWrite && Address < 8'd32) begin
      mem[Address[4:0]] <= WriteData;
    end
  end

  assign ReadData = (Address < 8'd32) ? mem[Address[4:0]] : 8'h00;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, expv);
  endtask

  function automatic logic [7:0] ref_rd(input logic [7:0] a);
    return (a < 8'd32) ? ref_mem[a[4:0]] : 8'h00;
  endfunction

  // Every busy cycle carries exactly one strobe, matched in order to the model trace.
  always @(negedge clk) begin
    if (clr && chk_en) begin
      op_t e;
      chk("strobe_excl", 32'(MemRead & MemWrite), 32'd0);
      chk("busy_vs_strobe", 32'(busy), 32'(MemRead | MemWrite));
      if (MemRead || MemWrite) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_strobe: got wr=%0b addr=%0h, expected no strobe", MemWrite, Address);
        end else begin
          e = exp_q.pop_front();
          chk("strobe_kind", 32'(MemWrite), 32'(e.wr));
          chk("address", 32'(Address), 32'(e.a));
          if (e.wr) chk("write_data", 32'(WriteData), 32'(e.d));
        end
      end
    end
  end

  task automatic run_op(input logic [1:0] m, input logic [7:0] s, input logic [7:0] d,
                        input logic [7:0] l, input logic [7:0] f,
                        input int poke, input int abort_at, output int lat_o);
    int lim, n, cyc;
    logic [7:0] sum, dat, sa, da;
    lim = (abort_at > 0) ? abort_at : (1 << 20);
    n   = 0;
    sum = 8'h00;
    if (m != 2'b11 && l != 8'h00) begin
      for (int k = 0; k < int'(l); k++) begin
        sa = s + 8'(k);
        da = d + 8'(k);
        case (m)
          2'b00: begin
            if (n < lim) begin
              dat = ref_rd(sa);
              exp_q.push_back('{wr: 1'b0, a: sa, d: 8'h00});
              exp_last_addr = sa;
              n++;
              if (n < lim) begin
                exp_q.push_back('{wr: 1'b1, a: da, d: dat});
                if (da < 8'd32) ref_mem[da[4:0]] = dat;
                exp_last_addr = da;
                n++;
              end
            end
          end
          2'b01: begin
            if (n < lim) begin
              exp_q.push_back('{wr: 1'b1, a: da, d: f});
              if (da < 8'd32) ref_mem[da[4:0]] = f;
              exp_last_addr = da;
              n++;
            end
          end
          default: begin
            if (n < lim) begin
              sum = sum + ref_rd(sa);
              exp_q.push_back('{wr: 1'b0, a: sa, d: 8'h00});
              exp_last_addr = sa;
              n++;
            end
          end
        endcase
      end
    end
    exp_err = (m == 2'b11);
    if (m == 2'b10) exp_csum = sum;

    @(negedge clk);
    start = 1'b1; mode = m; src_addr = s; dst_addr = d; length = l; fill_value = f;
    @(negedge clk);
    cyc = 1;
    while (1) begin
      start = (cyc == poke);
      if (cyc == poke) begin
        mode = 2'b01; dst_addr = 8'h00; length = 8'h05; fill_value = 8'h33;
      end
      abort = (cyc == abort_at);
      if (done || cyc > 600) break;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    abort = 1'b0;
    lat_o = cyc;
    chk("latency", 32'(cyc), 32'(n + 1));
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("idle_not_busy", 32'(busy), 32'd0);
    chk("address_hold", 32'(Address), 32'(exp_last_addr));
    chk("trace_complete", 32'(exp_q.size()), 32'd0);
    chk("checksum", 32'(checksum), 32'(exp_csum));
    chk("err", 32'(err), 32'(exp_err));
    exp_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 16; i++) begin
      ref_mem[i]      = 8'(i);
      ref_mem[i + 16] = 8'(-i);
    end

    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_memread", 32'(MemRead), 32'd0);
    chk("rst_memwrite", 32'(MemWrite), 32'd0);
    chk("rst_address", 32'(Address), 32'd0);
    chk("rst_wdata", 32'(WriteData), 32'd0);
    chk("rst_checksum", 32'(checksum), 32'd0);
    @(negedge clk);
    clr = 1'b1;
    chk_en = 1'b1;

    // checksums over the pristine image
    run_op(2'b10, 8'h00, 8'h00, 8'd16, 8'h00, 0, 0, lat);
    chk("csum_lo_lit", 32'(checksum), 32'h78);
    chk("csum_lo_lat", 32'(lat), 32'd17);
    run_op(2'b10, 8'h10, 8'h00, 8'd16, 8'h00, 0, 0, lat);
    chk("csum_hi_lit", 32'(checksum), 32'h88);

    // copy 0x00 -> 0x14, 4 bytes
    run_op(2'b00, 8'h00, 8'h14, 8'd4, 8'h00, 0, 0, lat);
    chk("copy_lat_lit", 32'(lat), 32'd9);
    chk("copy_m20", 32'(mem[20]), 32'h00);
    chk("copy_m21", 32'(mem[21]), 32'h01);
    chk("copy_m23", 32'(mem[23]), 32'h03);
    chk("copy_m24", 32'(mem[24]), 32'hF8);
    chk("csum_kept_lit", 32'(checksum), 32'h88);

    // fill 0x04..0x06 with AA
    run_op(2'b01, 8'h00, 8'h04, 8'd3, 8'hAA, 0, 0, lat);
    chk("fill_lat_lit", 32'(lat), 32'd4);
    chk("fill_m4", 32'(mem[4]), 32'hAA);
    chk("fill_m6", 32'(mem[6]), 32'hAA);
    chk("fill_m7", 32'(mem[7]), 32'h07);

    // null and reserved operations
    run_op(2'b11, 8'h00, 8'h00, 8'd5, 8'h00, 0, 0, lat);
    chk("rsvd_err_lit", 32'(err), 32'd1);
    chk("rsvd_lat_lit", 32'(lat), 32'd1);
    run_op(2'b00, 8'h00, 8'h10, 8'd0, 8'h00, 0, 0, lat);
    chk("len0_err_clear", 32'(err), 32'd0);
    run_op(2'b01, 8'h00, 8'h10, 8'd0, 8'h55, 0, 0, lat);
    run_op(2'b11, 8'h00, 8'h00, 8'd0, 8'h00, 0, 0, lat);
    run_op(2'b10, 8'h00, 8'h00, 8'd0, 8'h00, 0, 0, lat);

    // wrapping source with a start pulse mid-operation
    run_op(2'b00, 8'hFF, 8'h08, 8'd2, 8'h00, 2, 0, lat);
    chk("wrap_m8", 32'(mem[8]), 32'h00);
    chk("wrap_m9", 32'(mem[9]), 32'h00);
    chk("wrap_m0", 32'(mem[0]), 32'h00);

    // abort a copy during its third busy cycle
    run_op(2'b01, 8'h00, 8'h14, 8'd4, 8'hEE, 0, 0, lat);
    run_op(2'b00, 8'h00, 8'h14, 8'd4, 8'h00, 0, 3, lat);
    chk("abort_lat_lit", 32'(lat), 32'd4);
    chk("abort_m20", 32'(mem[20]), 32'h00);
    chk("abort_m21", 32'(mem[21]), 32'hEE);

    run_op(2'b10, 8'h00, 8'h00, 8'd4, 8'h00, 0, 0, lat);
    chk("csum4_lit", 32'(checksum), 32'h06);

    // asynchronous reset in the middle of a fill
    for (int k = 0; k < 5; k++) exp_q.push_back('{wr: 1'b1, a: 8'h18 + 8'(k), d: 8'h55});
    @(negedge clk);
    start = 1'b1; mode = 2'b01; dst_addr = 8'h18; length = 8'd5; fill_value = 8'h55;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 clr = 1'b0;
    #1;
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_done", 32'(done), 32'd0);
    chk("mid_err", 32'(err), 32'd0);
    chk("mid_memread", 32'(MemRead), 32'd0);
    chk("mid_memwrite", 32'(MemWrite), 32'd0);
    chk("mid_address", 32'(Address), 32'd0);
    chk("mid_wdata", 32'(WriteData), 32'd0);
    chk("mid_checksum", 32'(checksum), 32'd0);
    ref_mem[24] = 8'h55;
    ref_mem[25] = 8'h55;
    @(negedge clk);
    @(negedge clk);
    chk("mid_m18", 32'(mem[24]), 32'h55);
    chk("mid_m1a", 32'(mem[26]), 32'hF6);
    exp_q.delete();
    clr = 1'b1;
    exp_csum = 8'h00;
    exp_err = 1'b0;
    exp_last_addr = 8'h00;

    run_op(2'b01, 8'h00, 8'h1E, 8'd3, 8'h3C, 0, 0, lat);
    chk("tail_m31", 32'(mem[31]), 32'h3C);

    for (int i = 0; i < 32; i++) chk($sformatf("mem_%0d", i), 32'(mem[i]), 32'(ref_mem[i]));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
